// File: rtl/ahb_sram_arbiter.sv
// Round-robin arbiter that turns valid/ready requests into single AHB-lite transfers
// toward one SRAM controller slave, with alignment screening and a stalled-slave timeout.
module ahb_sram_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                  hclk,
  input  logic                  hreset,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ-1:0]    req_write,
  input  logic [3*NUM_REQ-1:0]  req_size,
  input  logic [AW*NUM_REQ-1:0] req_addr,
  input  logic [DW*NUM_REQ-1:0] req_wdata,
  output logic [NUM_REQ-1:0]    rsp_valid,
  output logic                  rsp_err,
  output logic [DW-1:0]         rsp_rdata,
  output logic                  hsel,
  output logic [1:0]            htrans,
  output logic                  hwrite,
  output logic [2:0]            hsize,
  output logic [AW-1:0]         haddr,
  output logic [DW-1:0]         hwdata,
  output logic                  hready,
  input  logic                  hready_resp,
  input  logic [1:0]            hresp,
  input  logic [DW-1:0]         hrdata
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;
  localparam logic [1:0] RESP_ERROR   = 2'b01;

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_ERRQ} state_t;

  state_t          state;
  logic [IW-1:0]   rr_ptr;
  logic [IW-1:0]   owner;
  logic [IW-1:0]   grant_idx;
  logic            grant_found;
  logic            bad_req;
  logic [CW-1:0]   dcnt;
  logic [DW-1:0]   lat_wdata;

  logic [2:0]      size_arr  [NUM_REQ];
  logic [AW-1:0]   addr_arr  [NUM_REQ];
  logic [DW-1:0]   wdata_arr [NUM_REQ];

  function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] base, input int off);
    int s;
    s = (int'(base) + off) % NUM_REQ;
    return IW'(s);
  endfunction

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      size_arr[i]  = req_size[i*3 +: 3];
      addr_arr[i]  = req_addr[i*AW +: AW];
      wdata_arr[i] = req_wdata[i*DW +: DW];
    end
  end

  // Scan from the farthest candidate back to rr_ptr so the closest valid one wins.
  // NOTE: every variable assigned in always_comb gets a default first, otherwise a latch is inferred.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[wrap_idx(rr_ptr, i)]) begin
        grant_found = 1'b1;
        grant_idx   = wrap_idx(rr_ptr, i);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state == S_IDLE && grant_found && !hreset) req_ready[grant_idx] = 1'b1;
  end

  assign bad_req = (size_arr[grant_idx] > 3'd2) ||
                   (size_arr[grant_idx] == 3'd1 && addr_arr[grant_idx][0]) ||
                   (size_arr[grant_idx] == 3'd2 && addr_arr[grant_idx][1:0] != 2'b00);

  assign hready = hready_resp;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge hclk) begin
    if (hreset) begin
      state     <= S_IDLE;
      rr_ptr    <= '0;
      owner     <= '0;
      dcnt      <= '0;
      lat_wdata <= '0;
      rsp_valid <= '0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      hsel      <= 1'b0;
      htrans    <= TRANS_IDLE;
      hwrite    <= 1'b0;
      hsize     <= '0;
      haddr     <= '0;
      hwdata    <= '0;
    end else begin
      rsp_valid <= '0;
      unique case (state)
        S_IDLE: begin
          if (grant_found) begin
            owner     <= grant_idx;
            rr_ptr    <= (grant_idx == IW'(NUM_REQ - 1)) ? '0 : grant_idx + IW'(1);
            lat_wdata <= wdata_arr[grant_idx];
            if (bad_req) begin
              state <= S_ERRQ;
            end else begin
              state  <= S_ADDR;
              hsel   <= 1'b1;
              htrans <= TRANS_NONSEQ;
              hwrite <= req_write[grant_idx];
              hsize  <= size_arr[grant_idx];
              haddr  <= addr_arr[grant_idx];
            end
          end
        end
        S_ADDR: begin
          hsel   <= 1'b0;
          htrans <= TRANS_IDLE;
          hwdata <= lat_wdata;
          dcnt   <= '0;
          state  <= S_DATA;
        end
        S_DATA: begin
          // hwrite still holds the direction of the transfer in flight.
          if (hready_resp) begin
            rsp_valid[owner] <= 1'b1;
            rsp_err          <= (hresp == RESP_ERROR);
            if (!hwrite) rsp_rdata <= hrdata;
            state            <= S_IDLE;
          end else if (dcnt == CW'(TIMEOUT - 1)) begin
            rsp_valid[owner] <= 1'b1;
            rsp_err          <= 1'b1;
            state            <= S_IDLE;
          end else begin
            dcnt <= dcnt + CW'(1);
          end
        end
        S_ERRQ: begin
          rsp_valid[owner] <= 1'b1;
          rsp_err          <= 1'b1;
          state            <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_sram_arbiter.sv
// Directed bench for ahb_sram_arbiter: small word-addressed SRAM slave with
// programmable wait states, ERROR responses and an indefinite stall.
module tb_ahb_sram_arbiter;

  localparam int NUM_REQ = 2;
  localparam int AW      = 32;
  localparam int DW      = 32;
  localparam int TIMEOUT = 16;

  logic                  hclk = 1'b0;
  logic                  hreset;
  logic [NUM_REQ-1:0]    req_valid, req_ready, req_write, rsp_valid;
  logic [3*NUM_REQ-1:0]  req_size;
  logic [AW*NUM_REQ-1:0] req_addr;
  logic [DW*NUM_REQ-1:0] req_wdata;
  logic                  rsp_err, hsel, hwrite, hready, hready_resp;
  logic [DW-1:0]         rsp_rdata, hwdata, hrdata;
  logic [1:0]            htrans, hresp;
  logic [2:0]            hsize;
  logic [AW-1:0]         haddr;

  int total = 0;
  int bad   = 0;

  always #5 hclk = ~hclk;

  ahb_sram_arbiter #(.NUM_REQ(NUM_REQ), .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .hclk(hclk), .hreset(hreset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .hsel(hsel), .htrans(htrans), .hwrite(hwrite), .hsize(hsize), .haddr(haddr),
    .hwdata(hwdata), .hready(hready), .hready_resp(hready_resp), .hresp(hresp),
    .hrdata(hrdata)
  );

  // Slave model
  logic        dphase = 1'b0;
  logic [3:0]  dp_word;
  logic        dp_write;
  int          wcnt = 0;
  logic        stall = 1'b0;
  logic        err_mode = 1'b0;
  int          wait_states = 0;
  logic [31:0] mem [16];

  assign hready_resp = !dphase ? 1'b1 : (!stall && wcnt >= wait_states);
  assign hresp       = (dphase && err_mode) ? 2'b01 : 2'b00;
  assign hrdata      = (dphase && !dp_write) ? mem[dp_word] : '0;

  always @(posedge hclk) begin
    if (hreset) begin
      dphase <= 1'b0;
    end else begin
      if (dphase && hready_resp) begin
        if (dp_write) mem[dp_word] <= hwdata;
        dphase <= 1'b0;
      end else if (dphase) begin
        wcnt <= wcnt + 1;
      end
      if (hsel && htrans == 2'b10) begin
        dphase   <= 1'b1;
        dp_word  <= haddr[5:2];
        dp_write <= hwrite;
        wcnt     <= 0;
      end
    end
  end

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic present(input int r, input logic wr, input logic [2:0] sz,
                         input logic [31:0] a, input logic [31:0] d);
    req_valid[r]          = 1'b1;
    req_write[r]          = wr;
    req_size[r*3 +: 3]    = sz;
    req_addr[r*AW +: AW]  = a;
    req_wdata[r*DW +: DW] = d;
  endtask

  task automatic test_reset();
    hreset = 1'b1;
    req_valid = '0;
    tick();
    tick();
    hreset = 1'b0;
    #1;
    total++; if (req_ready !== 2'b00) begin bad++; $display("FAIL reset_ready got=%b want=00", req_ready); end
    total++; if (rsp_valid !== 2'b00 || rsp_err !== 1'b0) begin bad++; $display("FAIL reset_rsp got valid=%b err=%b want 00/0", rsp_valid, rsp_err); end
    total++; if (rsp_rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h want=0", rsp_rdata); end
    total++; if ({hsel, htrans, hwrite, hsize, haddr, hwdata} !== '0) begin bad++; $display("FAIL reset_bus got hsel=%b htrans=%b hwrite=%b hsize=%h haddr=%h hwdata=%h want all 0", hsel, htrans, hwrite, hsize, haddr, hwdata); end
  endtask

  task automatic test_write();
    present(0, 1'b1, 3'd2, 32'h10, 32'hA5A5_1234);
    #1;
    total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL wr_ready got=%b want=01", req_ready); end
    tick();
    req_valid = '0;
    total++; if (hsel !== 1'b1 || htrans !== 2'b10) begin bad++; $display("FAIL wr_nonseq got hsel=%b htrans=%b want 1/10", hsel, htrans); end
    total++; if (haddr !== 32'h10 || hwrite !== 1'b1 || hsize !== 3'd2) begin bad++; $display("FAIL wr_addr got haddr=%h hwrite=%b hsize=%0d want 10/1/2", haddr, hwrite, hsize); end
    tick();
    total++; if (hsel !== 1'b0 || htrans !== 2'b00) begin bad++; $display("FAIL wr_dphase_idle got hsel=%b htrans=%b want 0/00", hsel, htrans); end
    total++; if (hwdata !== 32'hA5A5_1234) begin bad++; $display("FAIL wr_hwdata got=%h want=a5a51234", hwdata); end
    total++; if (rsp_valid !== 2'b00) begin bad++; $display("FAIL wr_early_rsp got=%b want=00", rsp_valid); end
    tick();
    total++; if (rsp_valid !== 2'b01 || rsp_err !== 1'b0) begin bad++; $display("FAIL wr_rsp got valid=%b err=%b want 01/0", rsp_valid, rsp_err); end
  endtask

  task automatic test_read();
    present(0, 1'b0, 3'd2, 32'h10, 32'h0);
    #1;
    total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL rd_ready got=%b want=01", req_ready); end
    tick();
    req_valid = '0;
    total++; if (htrans !== 2'b10 || hwrite !== 1'b0) begin bad++; $display("FAIL rd_nonseq got htrans=%b hwrite=%b want 10/0", htrans, hwrite); end
    tick();
    tick();
    total++; if (rsp_valid !== 2'b01 || rsp_err !== 1'b0) begin bad++; $display("FAIL rd_rsp got valid=%b err=%b want 01/0", rsp_valid, rsp_err); end
    total++; if (rsp_rdata !== 32'hA5A5_1234) begin bad++; $display("FAIL rd_data got=%h want=a5a51234", rsp_rdata); end
  endtask

  task automatic test_round_robin();
    int gseq [4];
    int ng = 0;
    int nr = 0;
    hreset = 1'b1;
    tick();
    hreset = 1'b0;
    present(0, 1'b0, 3'd2, 32'h10, 32'h0);
    present(1, 1'b0, 3'd2, 32'h10, 32'h0);
    #1;
    for (int c = 0; c < 40 && nr < 4; c++) begin
      if (req_ready != 2'b00 && ng < 4) begin
        total++; if ($countones(req_ready) != 1) begin bad++; $display("FAIL rr_onehot got=%b want one-hot", req_ready); end
        gseq[ng] = (req_ready == 2'b10) ? 1 : 0;
        ng++;
      end
      tick();
      if (ng == 4) req_valid = '0;
      if (rsp_valid != 2'b00) begin
        total++; if (rsp_valid !== (gseq[nr] == 1 ? 2'b10 : 2'b01) || rsp_rdata !== 32'hA5A5_1234) begin bad++; $display("FAIL rr_rsp%0d got valid=%b data=%h want owner %0d data a5a51234", nr, rsp_valid, rsp_rdata, gseq[nr]); end
        nr++;
      end
      #1;
    end
    total++; if (ng != 4 || nr != 4) begin bad++; $display("FAIL rr_count got grants=%0d rsps=%0d want 4/4", ng, nr); end
    total++; if (gseq[0] != 0 || gseq[1] != 1 || gseq[2] != 0 || gseq[3] != 1) begin bad++; $display("FAIL rr_order got %0d%0d%0d%0d want 0101", gseq[0], gseq[1], gseq[2], gseq[3]); end
  endtask

  task automatic test_misaligned();
    present(1, 1'b1, 3'd2, 32'h02, 32'h1234);
    #1;
    total++; if (req_ready !== 2'b10) begin bad++; $display("FAIL mis_ready got=%b want=10", req_ready); end
    tick();
    req_valid = '0;
    total++; if (htrans !== 2'b00 || hsel !== 1'b0 || rsp_valid !== 2'b00) begin bad++; $display("FAIL mis_nobus got htrans=%b hsel=%b rsp=%b want 00/0/00", htrans, hsel, rsp_valid); end
    tick();
    total++; if (rsp_valid !== 2'b10 || rsp_err !== 1'b1 || htrans !== 2'b00) begin bad++; $display("FAIL mis_rsp got valid=%b err=%b htrans=%b want 10/1/00", rsp_valid, rsp_err, htrans); end
    present(0, 1'b0, 3'd3, 32'h0, 32'h0);
    #1;
    total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL size3_ready got=%b want=01", req_ready); end
    tick();
    req_valid = '0;
    total++; if (htrans !== 2'b00) begin bad++; $display("FAIL size3_nobus got htrans=%b want=00", htrans); end
    tick();
    total++; if (rsp_valid !== 2'b01 || rsp_err !== 1'b1) begin bad++; $display("FAIL size3_rsp got valid=%b err=%b want 01/1", rsp_valid, rsp_err); end
  endtask

  task automatic test_timeout();
    logic early = 1'b0;
    stall = 1'b1;
    present(0, 1'b0, 3'd2, 32'h10, 32'h0);
    #1;
    total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL to_ready got=%b want=01", req_ready); end
    tick();
    req_valid = '0;
    total++; if (htrans !== 2'b10) begin bad++; $display("FAIL to_nonseq got htrans=%b want=10", htrans); end
    for (int i = 0; i < TIMEOUT; i++) begin
      tick();
      if (rsp_valid != 2'b00) early = 1'b1;
    end
    total++; if (early !== 1'b0) begin bad++; $display("FAIL to_early got early=%b want=0", early); end
    tick();
    total++; if (rsp_valid !== 2'b01 || rsp_err !== 1'b1) begin bad++; $display("FAIL to_rsp got valid=%b err=%b want 01/1", rsp_valid, rsp_err); end
    total++; if (rsp_rdata !== 32'hA5A5_1234) begin bad++; $display("FAIL to_rdata_kept got=%h want=a5a51234", rsp_rdata); end
    stall = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_err_resp();
    err_mode = 1'b1;
    wait_states = 1;
    present(0, 1'b1, 3'd2, 32'h14, 32'hDEAD_BEEF);
    #1;
    total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL er_ready got=%b want=01", req_ready); end
    tick();
    req_valid = '0;
    tick();
    total++; if (hready !== 1'b0) begin bad++; $display("FAIL er_hready_low got=%b want=0", hready); end
    tick();
    total++; if (rsp_valid !== 2'b00 || hready !== 1'b1) begin bad++; $display("FAIL er_second got rsp=%b hready=%b want 00/1", rsp_valid, hready); end
    tick();
    total++; if (rsp_valid !== 2'b01 || rsp_err !== 1'b1) begin bad++; $display("FAIL er_rsp got valid=%b err=%b want 01/1", rsp_valid, rsp_err); end
    err_mode = 1'b0;
    wait_states = 0;
  endtask

  task automatic test_reset_mid();
    logic stray = 1'b0;
    stall = 1'b1;
    present(1, 1'b1, 3'd2, 32'h18, 32'h5555_AAAA);
    #1;
    total++; if (req_ready !== 2'b10) begin bad++; $display("FAIL rm_ready got=%b want=10", req_ready); end
    tick();
    req_valid = '0;
    tick();
    total++; if (hwdata !== 32'h5555_AAAA) begin bad++; $display("FAIL rm_hwdata got=%h want=5555aaaa", hwdata); end
    hreset = 1'b1;
    tick();
    hreset = 1'b0;
    stall = 1'b0;
    #1;
    total++; if ({hsel, htrans, hwrite, hsize, haddr, hwdata} !== '0 || req_ready !== 2'b00) begin bad++; $display("FAIL rm_bus got hsel=%b htrans=%b haddr=%h hwdata=%h ready=%b want all 0", hsel, htrans, haddr, hwdata, req_ready); end
    total++; if (rsp_valid !== 2'b00 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin bad++; $display("FAIL rm_rsp got valid=%b err=%b data=%h want 00/0/0", rsp_valid, rsp_err, rsp_rdata); end
    for (int i = 0; i < 4; i++) begin
      tick();
      if (rsp_valid != 2'b00) stray = 1'b1;
    end
    total++; if (stray !== 1'b0) begin bad++; $display("FAIL rm_stray got=%b want=0", stray); end
    present(0, 1'b0, 3'd2, 32'h10, 32'h0);
    #1;
    total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL rm_next_ready got=%b want=01", req_ready); end
    tick();
    req_valid = '0;
    tick();
    tick();
    total++; if (rsp_valid !== 2'b01 || rsp_err !== 1'b0 || rsp_rdata !== 32'hA5A5_1234) begin bad++; $display("FAIL rm_next_rsp got valid=%b err=%b data=%h want 01/0/a5a51234", rsp_valid, rsp_err, rsp_rdata); end
  endtask

  initial begin
    hreset    = 1'b1;
    req_valid = '0;
    req_write = '0;
    req_size  = '0;
    req_addr  = '0;
    req_wdata = '0;
    test_reset();
    test_write();
    test_read();
    test_round_robin();
    test_misaligned();
    test_timeout();
    test_err_resp();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
